// File: rtl/mdp_packet_writer.sv
// Serializes one MSG_BYTES-wide message, MSB byte first, into byte-wide Avalon-MM writes.
// Define MDP_WRITER_CHECKSUM_EN to append an XOR checksum write after the final message byte.
module mdp_packet_writer #(
  parameter int MSG_BYTES  = 37,
  parameter int ADDR_W     = 3,
  parameter int GAP_CYCLES = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [8*MSG_BYTES-1:0] msg_data_i,
  input  logic                   msg_valid_i,
  output logic                   msg_ready_o,
  output logic [ADDR_W-1:0]      av_address_o,
  output logic [7:0]             av_writedata_o,
  output logic                   av_write_o,
  output logic                   av_chipselect_o,
  input  logic                   av_waitrequest_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [7:0]             byte_count_o
);

  localparam int MSG_W  = 8 * MSG_BYTES;
  localparam int IDX_N  = $clog2(MSG_BYTES + 2);
  localparam int IDX_W  = (IDX_N > ADDR_W) ? IDX_N : ADDR_W;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`ifdef MDP_WRITER_CHECKSUM_EN
  localparam int LAST_IDX = MSG_BYTES;
`else
  localparam int LAST_IDX = MSG_BYTES - 1;
`endif

  typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} state_t;

  state_t             state_q, state_d;
  logic [MSG_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         count_q, count_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [7:0]         wr_byte;
  logic               accept;

`ifdef MDP_WRITER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;

  // Index MSG_BYTES is the checksum slot; its address falls out of idx_q naturally.
  assign wr_byte = (idx_q == IDX_W'(MSG_BYTES)) ? xor_q : shift_q[MSG_W-1 -: 8];

  always_comb begin
    xor_d = xor_q;
    if (state_q == IDLE && msg_valid_i) begin
      xor_d = 8'h00;
    end else if (accept) begin
      xor_d = xor_q ^ wr_byte;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      xor_q <= 8'h00;
    end else begin
      xor_q <= xor_d;
    end
  end
`else
  assign wr_byte = shift_q[MSG_W-1 -: 8];
`endif

  assign accept = (state_q == WRITE) && !av_waitrequest_i;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    count_d = count_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (msg_valid_i) begin
          shift_d = msg_data_i;
          idx_d   = '0;
          count_d = 8'h00;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          shift_d = {shift_q[MSG_W-9:0], 8'h00};
          idx_d   = idx_q + IDX_W'(1);
          if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
          if (idx_q == IDX_W'(LAST_IDX)) begin
            state_d = DONE;
          end else if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GAP_W'(GAP_CYCLES - 1);
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = WRITE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      count_q <= 8'h00;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      gap_q   <= gap_d;
    end
  end

  // Bus outputs are forced to zero outside WRITE so an abort leaves the slave port quiet.
  always_comb begin
    msg_ready_o     = (state_q == IDLE);
    busy_o          = (state_q != IDLE);
    done_o          = (state_q == DONE);
    av_write_o      = (state_q == WRITE);
    av_chipselect_o = (state_q == WRITE);
    av_address_o    = '0;
    av_writedata_o  = 8'h00;
    if (state_q == WRITE) begin
      av_address_o   = idx_q[ADDR_W-1:0];
      av_writedata_o = wr_byte;
    end
    byte_count_o = count_q;
  end

endmodule

// File: tb/tb_mdp_packet_writer.sv
// Scoreboard bench for mdp_packet_writer: instance A (no gap, stall control), instance B (GAP_CYCLES=2).
// Expectations follow MDP_WRITER_CHECKSUM_EN when the bench is built with it.
module tb_mdp_packet_writer;
  localparam int MB = 37;
  localparam int MW = 8 * MB;
`ifdef MDP_WRITER_CHECKSUM_EN
  localparam int NWR = MB + 1;
`else
  localparam int NWR = MB;
`endif

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [MW-1:0] a_data, b_data;
  logic a_valid, a_ready, a_wr, a_cs, a_wait, a_busy, a_done;
  logic b_valid, b_ready, b_wr, b_cs, b_wait, b_busy, b_done;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_wd, b_wd, a_cnt, b_cnt;

  mdp_packet_writer #(.MSG_BYTES(MB), .ADDR_W(3), .GAP_CYCLES(0)) u_a (
    .clk_i(clk), .reset_n_i(rst_n), .msg_data_i(a_data), .msg_valid_i(a_valid),
    .msg_ready_o(a_ready), .av_address_o(a_addr), .av_writedata_o(a_wd),
    .av_write_o(a_wr), .av_chipselect_o(a_cs), .av_waitrequest_i(a_wait),
    .busy_o(a_busy), .done_o(a_done), .byte_count_o(a_cnt));

  mdp_packet_writer #(.MSG_BYTES(MB), .ADDR_W(3), .GAP_CYCLES(2)) u_b (
    .clk_i(clk), .reset_n_i(rst_n), .msg_data_i(b_data), .msg_valid_i(b_valid),
    .msg_ready_o(b_ready), .av_address_o(b_addr), .av_writedata_o(b_wd),
    .av_write_o(b_wr), .av_chipselect_o(b_cs), .av_waitrequest_i(b_wait),
    .busy_o(b_busy), .done_o(b_done), .byte_count_o(b_cnt));

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int total = 0;
  int bad = 0;
  int a_acc = 0;
  int a_done_seen = 0;
  logic [10:0] a_log [0:1023];
  logic a_last_prev = 1'b0;
  logic b_last_prev = 1'b0;
  int b_idle = 0;
  bit b_started = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic [MW-1:0] m, input bit to_b);
    exp_t e;
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < MB; i++) begin
      e.addr = 3'(i);
      e.data = m[MW-1-8*i -: 8];
      e.last = (i == NWR - 1);
      x = x ^ e.data;
      if (to_b) qb.push_back(e); else qa.push_back(e);
    end
`ifdef MDP_WRITER_CHECKSUM_EN
    e.addr = 3'(MB);
    e.data = x;
    e.last = 1'b1;
    if (to_b) qb.push_back(e); else qa.push_back(e);
`endif
  endtask

  // Monitor A: pops on every accepted write, checks held values during stalls.
  always @(negedge clk) begin
    if (a_wr && a_wait && qa.size() > 0) begin
      chk("a_hold_addr", int'(a_addr), int'(qa[0].addr));
      chk("a_hold_data", int'(a_wd), int'(qa[0].data));
    end
    if (a_done) begin
      chk("a_done_after_last", int'(a_last_prev), 1);
      a_done_seen++;
    end
    a_last_prev = 1'b0;
    if (a_wr && !a_wait) begin
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected_write: got %0h@%0d expected none", a_wd, a_addr);
      end else begin
        ea = qa.pop_front();
        chk("a_wr_addr", int'(a_addr), int'(ea.addr));
        chk("a_wr_data", int'(a_wd), int'(ea.data));
        chk("a_wr_cs", int'(a_cs), 1);
        a_last_prev = ea.last;
      end
      a_log[a_acc % 1024] = {a_addr, a_wd};
      a_acc++;
    end
    chk("a_ready_vs_busy", int'(a_ready), int'(!a_busy));
  end

  // Monitor B: also measures idle cycles between consecutive accepted writes.
  always @(negedge clk) begin
    if (b_done) begin
      chk("b_done_after_last", int'(b_last_prev), 1);
      b_started = 1'b0;
    end
    b_last_prev = 1'b0;
    if (b_wr && !b_wait) begin
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected_write: got %0h@%0d expected none", b_wd, b_addr);
      end else begin
        eb = qb.pop_front();
        chk("b_wr_addr", int'(b_addr), int'(eb.addr));
        chk("b_wr_data", int'(b_wd), int'(eb.data));
        b_last_prev = eb.last;
      end
      if (b_started) chk("b_gap_len", b_idle, 2);
      b_started = 1'b1;
      b_idle = 0;
    end else if (b_busy && !b_wr && !b_done) begin
      b_idle++;
    end
  end

  task automatic send_a(input logic [MW-1:0] m, input int stall_at, input int stall_n,
                        output int phase, output int base);
    int left;
    bit got;
    left = stall_n;
    got = 1'b0;
    phase = -1;
    base = 0;
    push_exp(m, 1'b0);
    @(posedge clk); #1;
    a_data = m;
    a_valid = 1'b1;
    for (int k = 1; k <= 400 && !got; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        a_valid = 1'b0;
        base = a_acc;
      end
      if (left > 0 && a_wr && (a_acc - base) == stall_at) begin
        a_wait = 1'b1;
        left--;
      end else begin
        a_wait = 1'b0;
      end
      @(negedge clk);
      if (k == 1) begin
        chk("a_first_count", int'(a_cnt), 0);
        chk("a_first_addr", int'(a_addr), 0);
      end
      if (a_done) begin
        got = 1'b1;
        phase = k - 1;
        chk("a_done_count", int'(a_cnt), NWR);
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL a_done_timeout: got no done expected done within 400 cycles");
    end
    @(negedge clk);
    chk("a_ready_after_done", int'(a_ready), 1);
    chk("a_count_held", int'(a_cnt), NWR);
  endtask

  task automatic wait_a_done(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (a_done) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s: got no done expected done within 400 cycles", name);
    end
  endtask

  logic [MW-1:0] msg_a, msg_b, msg_c;
  int phase, base, base2, done0;
  bit got;

  initial begin
    msg_a = 296'hC0C21C023D0100006803800100007B0000000C000000A0475F3B000000000F0002C9000000;
    msg_b = {8'hA5, 8'h5A, {35{8'h3C}}};
    msg_c = {8'hC0, 8'hC2, {35{8'h00}}};
    rst_n = 1'b0;
    a_data = '0; a_valid = 1'b0; a_wait = 1'b0;
    b_data = '0; b_valid = 1'b0; b_wait = 1'b0;
    #12;
    chk("rst_ready", int'(a_ready), 1);
    chk("rst_write", int'(a_wr), 0);
    chk("rst_cs", int'(a_cs), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_done", int'(a_done), 0);
    chk("rst_addr", int'(a_addr), 0);
    chk("rst_data", int'(a_wd), 0);
    chk("rst_count", int'(a_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Plain message, no stalls.
    send_a(msg_a, 0, 0, phase, base);
    chk("a_phase_nostall", phase, NWR);
    chk("a_log_first", int'(a_log[base]), 'h0C0);
    chk("a_log_second", int'(a_log[base + 1]), 'h1C2);
    chk("a_log_wrap_addr", int'(a_log[base + 8][10:8]), 0);
    chk("a_log_last_msg_byte", int'(a_log[base + 36]), 'h400);

    // Three stall cycles on byte 5.
    send_a(msg_a, 5, 3, phase, base);
    chk("a_phase_stall", phase, NWR + 3);
    chk("a_log_stalled_byte", int'(a_log[base + 5]), 'h501);

    // msg_valid held high with a different second message throughout the first.
    push_exp(msg_a, 1'b0);
    push_exp(msg_b, 1'b0);
    @(posedge clk); #1;
    a_data = msg_a;
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_data = msg_b;
    base = a_acc;
    wait_a_done("a_b2b_first_timeout");
    chk("a_b2b_ready_in_done", int'(a_ready), 0);
    @(negedge clk);
    chk("a_b2b_ready_after", int'(a_ready), 1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    base2 = a_acc;
    @(negedge clk);
    chk("a_b2b_second_busy", int'(a_busy), 1);
    chk("a_b2b_second_first", (int'(a_addr) << 8) | int'(a_wd), 'h0A5);
    wait_a_done("a_b2b_second_timeout");
    @(negedge clk);
    chk("a_b2b_first_intact0", int'(a_log[base]), 'h0C0);
    chk("a_b2b_first_intact9", int'(a_log[base + 9]), 'h103);
    chk("a_b2b_second_log1", int'(a_log[base2 + 1]), 'h15A);
    chk("a_b2b_count", base2 - base, NWR);

    // Reset pulse after byte 10 has been accepted.
    push_exp(msg_a, 1'b0);
    done0 = a_done_seen;
    @(posedge clk); #1;
    a_data = msg_a;
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    base = a_acc;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk); #2;
      if (a_acc - base >= 10) got = 1'b1;
    end
    chk("a_rst_reached_byte10", a_acc - base, 10);
    #1;
    rst_n = 1'b0;
    #1;
    chk("a_rst_mid_write", int'(a_wr), 0);
    chk("a_rst_mid_cs", int'(a_cs), 0);
    chk("a_rst_mid_addr", int'(a_addr), 0);
    chk("a_rst_mid_data", int'(a_wd), 0);
    chk("a_rst_mid_busy", int'(a_busy), 0);
    chk("a_rst_mid_count", int'(a_cnt), 0);
    qa.delete();
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("a_rst_no_done", a_done_seen, done0);

    // Checksum pattern message (plain message without the checksum feature).
    send_a(msg_c, 0, 0, phase, base);
`ifdef MDP_WRITER_CHECKSUM_EN
    chk("a_chk_last_write", int'(a_log[base + 37]), 'h502);
`else
    chk("a_chk_last_write", int'(a_log[base + 36]), 'h400);
`endif
    chk("a_chk_first_after_rst", int'(a_log[base]), 'h0C0);

    // Instance B: two idle cycles between writes.
    push_exp(msg_a, 1'b1);
    @(posedge clk); #1;
    b_data = msg_a;
    b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    got = 1'b0;
    phase = -1;
    for (int k = 1; k <= 600 && !got; k++) begin
      @(negedge clk);
      if (b_done) begin
        got = 1'b1;
        phase = k - 1;
        chk("b_done_count", int'(b_cnt), NWR);
      end
    end
    chk("b_phase_gap", phase, NWR + (NWR - 1) * 2);
    @(negedge clk);
    chk("b_ready_after_done", int'(b_ready), 1);
    chk("b_queue_drained", qb.size(), 0);
    chk("a_queue_drained", qa.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
